// File: rtl/fix_float_pkg.sv
// fix_float_pkg: shared definitions for the fixed-to-float converter.
// Holds the controller state encoding, the parameter defaults and the
// exponent-bias / starting-exponent helpers.
package fix_float_pkg;

  localparam int DEF_IN_W     = 16;
  localparam int DEF_FRAC_W   = 8;
  localparam int DEF_EXP_W    = 5;
  localparam int DEF_MAN_W    = 10;
  localparam int DEF_ROUND_EN = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // IEEE-style exponent bias for an exp_w-bit exponent field.
  function automatic int exp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Biased exponent of a magnitude whose MSB (bit in_w-2) is the hidden
  // bit, i.e. the exponent before any normalisation shift.
  function automatic int start_exp(input int in_w, input int frac_w,
                                   input int exp_w);
    return exp_bias(exp_w) + (in_w - 2 - frac_w);
  endfunction

endpackage

// File: rtl/fp_round_rne.sv
// fp_round_rne: combinational mantissa rounding stage.
// Ports:
//   i_man  - truncated mantissa (hidden bit excluded)
//   i_grd  - bits below the mantissa (MSB = guard, rest = sticky)
//   i_exp  - biased exponent, widened to XW bits
//   o_man  - rounded mantissa (zero on carry-out)
//   o_exp  - rounded exponent, low EXP_W bits
//   o_ovf  - rounded exponent is at or above the all-ones code
module fp_round_rne #(
  parameter int MAN_W    = 10,
  parameter int LOW_W    = 4,
  parameter int EXP_W    = 5,
  parameter int XW       = 7,
  parameter int ROUND_EN = 1
) (
  input  logic [MAN_W-1:0] i_man,
  input  logic [LOW_W-1:0] i_grd,
  input  logic [XW-1:0]    i_exp,
  output logic [MAN_W-1:0] o_man,
  output logic [EXP_W-1:0] o_exp,
  output logic             o_ovf
);

  localparam logic [LOW_W-1:0] STICKY_MASK = {LOW_W{1'b1}} >> 1;
  localparam logic [XW-1:0]    EXP_MAX     = XW'((1 << EXP_W) - 1);

  logic           w_up;
  logic [MAN_W:0] w_sum;
  logic [XW-1:0]  w_exp;

  // Round-to-nearest-even decision, carry into the exponent, saturation flag.
  always_comb begin
    w_up  = 1'b0;
    w_sum = '0;
    w_exp = i_exp;
    if (ROUND_EN != 0) begin
      // Above half: guard set with any sticky bit; exact half: only if LSB odd.
      w_up = i_grd[LOW_W-1] & ((|(i_grd & STICKY_MASK)) | i_man[0]);
    end else begin
      w_up = 1'b0;
    end
    w_sum = {1'b0, i_man} + {{MAN_W{1'b0}}, w_up};
    // Carry-out means mantissa wrapped to zero: 1.111..1 + ulp = 10.000..0.
    w_exp = i_exp + {{(XW-1){1'b0}}, w_sum[MAN_W]};
    o_man = w_sum[MAN_W] ? {MAN_W{1'b0}} : w_sum[MAN_W-1:0];
    o_exp = w_exp[EXP_W-1:0];
    o_ovf = (w_exp >= EXP_MAX);
  end

endmodule

// File: rtl/fix_to_float_seq.sv
// fix_to_float_seq: sequential sign-magnitude fixed-point to float converter.
// Normalises one bit per clock, then rounds and registers the result.
// Ports:
//   clk    - clock, rising edge
//   reset  - asynchronous active-low reset
//   start  - conversion request, accepted in IDLE or DONE
//   din    - {sign, magnitude} operand
//   busy   - high while normalising or rounding
//   done   - result valid, held until the next accepted start
//   result - {sign, biased exponent, mantissa}
//   ovf    - result saturated to infinity
module fix_to_float_seq
  import fix_float_pkg::*;
#(
  parameter int IN_W     = DEF_IN_W,
  parameter int FRAC_W   = DEF_FRAC_W,
  parameter int EXP_W    = DEF_EXP_W,
  parameter int MAN_W    = DEF_MAN_W,
  parameter int ROUND_EN = DEF_ROUND_EN
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [IN_W-1:0]          din,
  output logic                     busy,
  output logic                     done,
  output logic [EXP_W+MAN_W:0]     result,
  output logic                     ovf
);

  localparam int MAG_W = IN_W - 1;
  // Bits below the stored mantissa; must be at least 1.
  localparam int LOW_W = IN_W - 2 - MAN_W;
  // Two spare bits keep large start exponents from wrapping.
  localparam int XW    = EXP_W + 2;
  localparam logic [XW-1:0] EXP_INIT = XW'(start_exp(IN_W, FRAC_W, EXP_W));
  localparam logic [XW-1:0] EXP_ONE  = {{(XW-1){1'b0}}, 1'b1};

  state_t             r_state;
  logic               r_sgn;
  logic [MAG_W-1:0]   r_mag;
  logic [XW-1:0]      r_exp;
  logic               r_uflow;

  logic               w_mag_zero;
  logic [MAN_W-1:0]   w_rnd_man;
  logic [EXP_W-1:0]   w_rnd_exp;
  logic               w_rnd_ovf;

  assign w_mag_zero = (r_mag == {MAG_W{1'b0}});

  fp_round_rne #(
    .MAN_W    (MAN_W),
    .LOW_W    (LOW_W),
    .EXP_W    (EXP_W),
    .XW       (XW),
    .ROUND_EN (ROUND_EN)
  ) u_round (
    .i_man (r_mag[IN_W-3 -: MAN_W]),
    .i_grd (r_mag[LOW_W-1:0]),
    .i_exp (r_exp),
    .o_man (w_rnd_man),
    .o_exp (w_rnd_exp),
    .o_ovf (w_rnd_ovf)
  );

  // Controller: capture, one-bit-per-cycle normalisation, registered result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_sgn   <= 1'b0;
      r_mag   <= '0;
      r_exp   <= '0;
      r_uflow <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      ovf     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_sgn   <= din[IN_W-1];
            r_mag   <= din[IN_W-2:0];
            r_exp   <= EXP_INIT;
            r_uflow <= 1'b0;
            busy    <= 1'b1;
            done    <= 1'b0;
            r_state <= ST_NORM;
          end
        end
        ST_NORM: begin
          if (w_mag_zero || r_mag[MAG_W-1]) begin
            r_state <= ST_ROUND;
          end else begin
            r_mag <= {r_mag[MAG_W-2:0], 1'b0};
            // Underflow keeps shifting so latency stays lz+2; the flag
            // forces a signed zero at the end instead of a subnormal.
            if (r_uflow || (r_exp <= EXP_ONE)) begin
              r_uflow <= 1'b1;
            end else begin
              r_exp <= r_exp - EXP_ONE;
            end
          end
        end
        ST_ROUND: begin
          busy    <= 1'b0;
          done    <= 1'b1;
          r_state <= ST_DONE;
          if (w_mag_zero || r_uflow) begin
            result <= {r_sgn, {(EXP_W+MAN_W){1'b0}}};
            ovf    <= 1'b0;
          end else if (w_rnd_ovf) begin
            result <= {r_sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            ovf    <= 1'b1;
          end else begin
            result <= {r_sgn, w_rnd_exp, w_rnd_man};
            ovf    <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fix_to_float_seq.sv
// tb_fix_to_float_seq: directed-vector bench for fix_to_float_seq.
// Three instances share the stimulus: defaults, truncation (ROUND_EN=0),
// and a 3-bit exponent variant that reaches overflow and underflow flush.
module tb_fix_to_float_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] din;

  logic        busy_d, done_d, ovf_d;
  logic [15:0] res_d;
  logic        busy_t, done_t, ovf_t;
  logic [15:0] res_t;
  logic        busy_e, done_e, ovf_e;
  logic [13:0] res_e;

  int n_cmp;
  int n_err;

  fix_to_float_seq u_dut (
    .clk(clk), .reset(reset), .start(start), .din(din),
    .busy(busy_d), .done(done_d), .result(res_d), .ovf(ovf_d)
  );

  fix_to_float_seq #(.ROUND_EN(0)) u_trn (
    .clk(clk), .reset(reset), .start(start), .din(din),
    .busy(busy_t), .done(done_t), .result(res_t), .ovf(ovf_t)
  );

  fix_to_float_seq #(.EXP_W(3)) u_e3 (
    .clk(clk), .reset(reset), .start(start), .din(din),
    .busy(busy_e), .done(done_e), .result(res_e), .ovf(ovf_e)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp_v);
    end
  endtask

  // Drive start for one edge (E0); checks done dropped and busy rose on E0.
  task automatic issue_start(input logic [15:0] d);
    @(negedge clk);
    din   = d;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk_val("done_low_after_start", {31'd0, done_d}, 32'd0);
    chk_val("busy_after_start", {31'd0, busy_d}, 32'd1);
  endtask

  // Count edges until done; lat_exp is counted from the current point.
  task automatic wait_done(input int lat_exp);
    int lat;
    lat = -1;
    for (int k = 1; k <= 64; k++) begin
      @(posedge clk);
      #1;
      if (done_d) begin
        lat = k;
        break;
      end
    end
    chk_val("latency", lat, lat_exp);
    chk_val("done_trn", {31'd0, done_t}, 32'd1);
    chk_val("done_e3", {31'd0, done_e}, 32'd1);
    chk_val("busy_clear", {31'd0, busy_d}, 32'd0);
  endtask

  typedef struct packed {
    logic [15:0] d;
    int          lat;
    logic [15:0] r_def;
    logic [15:0] r_trn;
    logic [13:0] r_e3;
    logic        o_e3;
  } vec_t;

  vec_t vecs [10] = '{
    '{16'h0100,  8, 16'h3C00, 16'h3C00, 14'h0C00, 1'b0},  // +1.0
    '{16'h8180,  8, 16'hBE00, 16'hBE00, 14'h2E00, 1'b0},  // -1.5
    '{16'h7FFF,  2, 16'h5800, 16'h57FF, 14'h1C00, 1'b1},  // max, carry
    '{16'h4008,  2, 16'h5400, 16'h5400, 14'h1C00, 1'b1},  // tie, even
    '{16'h4018,  2, 16'h5402, 16'h5401, 14'h1C00, 1'b1},  // tie, odd
    '{16'h4007,  2, 16'h5400, 16'h5400, 14'h1C00, 1'b1},  // below half
    '{16'h0000,  2, 16'h0000, 16'h0000, 14'h0000, 1'b0},  // +0
    '{16'h8000,  2, 16'h8000, 16'h8000, 14'h2000, 1'b0},  // -0
    '{16'h0FFF,  5, 16'h4C00, 16'h4BFF, 14'h1C00, 1'b1},  // carry into exp
    '{16'h8001, 16, 16'h9C00, 16'h9C00, 14'h2000, 1'b0}   // e3 flushes
  };

  initial begin
    n_cmp = 0;
    n_err = 0;
    clk   = 1'b0;
    reset = 1'b0;
    start = 1'b0;
    din   = 16'h0000;

    #12;
    chk_val("rst_busy", {31'd0, busy_d}, 32'd0);
    chk_val("rst_done", {31'd0, done_d}, 32'd0);
    chk_val("rst_result", {16'd0, res_d}, 32'd0);
    chk_val("rst_ovf", {31'd0, ovf_d}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Directed vectors, issued back-to-back from DONE.
    foreach (vecs[i]) begin
      issue_start(vecs[i].d);
      wait_done(vecs[i].lat);
      chk_val($sformatf("res_def_%h", vecs[i].d), {16'd0, res_d}, {16'd0, vecs[i].r_def});
      chk_val($sformatf("ovf_def_%h", vecs[i].d), {31'd0, ovf_d}, 32'd0);
      chk_val($sformatf("res_trn_%h", vecs[i].d), {16'd0, res_t}, {16'd0, vecs[i].r_trn});
      chk_val($sformatf("ovf_trn_%h", vecs[i].d), {31'd0, ovf_t}, 32'd0);
      chk_val($sformatf("res_e3_%h", vecs[i].d), {18'd0, res_e}, {18'd0, vecs[i].r_e3});
      chk_val($sformatf("ovf_e3_%h", vecs[i].d), {31'd0, ovf_e}, {31'd0, vecs[i].o_e3});
    end

    // Start pulsed while busy is ignored.
    issue_start(16'h0100);
    repeat (2) @(posedge clk);
    #1;
    din   = 16'h7FFF;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(5);
    chk_val("busy_ignore_res", {16'd0, res_d}, 32'h0000_3C00);
    repeat (3) @(posedge clk);
    #1;
    chk_val("hold_done", {31'd0, done_d}, 32'd1);
    chk_val("hold_res", {16'd0, res_d}, 32'h0000_3C00);

    // Reset in the middle of normalisation.
    issue_start(16'h0001);
    repeat (4) @(posedge clk);
    #1;
    chk_val("midnorm_busy", {31'd0, busy_d}, 32'd1);
    chk_val("midnorm_res_held", {16'd0, res_d}, 32'h0000_3C00);
    reset = 1'b0;
    #1;
    chk_val("arst_busy", {31'd0, busy_d}, 32'd0);
    chk_val("arst_done", {31'd0, done_d}, 32'd0);
    chk_val("arst_result", {16'd0, res_d}, 32'd0);
    chk_val("arst_ovf", {31'd0, ovf_d}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // First start after reset release is accepted immediately.
    issue_start(16'h8180);
    wait_done(8);
    chk_val("post_rst_res", {16'd0, res_d}, 32'h0000_BE00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fix_to_float_seq.md
FIX_TO_FLOAT_SEQ -- requirements
Module: fix_to_float_seq

Interface
REQ-001 SHALL have parameter IN_W, default 16, meaning total fixed-point input width: 1 sign bit plus an (IN_W-1)-bit sign-magnitude value.
REQ-002 SHALL have parameter FRAC_W, default 8, meaning fractional bits of the input magnitude.
REQ-003 SHALL have parameter EXP_W, default 5, meaning output exponent width.
REQ-004 SHALL have parameter MAN_W, default 10, meaning stored output mantissa width (hidden bit excluded).
REQ-005 SHALL have parameter ROUND_EN, default 1, meaning 1 = round-to-nearest-even and 0 = truncate.
REQ-006 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port start, input, 1 bit: conversion request, sampled on clk.
REQ-009 SHALL have port din, input, IN_W bits: {sign, magnitude} operand, captured when start is accepted.
REQ-010 SHALL have port busy, output, 1 bit: high in the NORM and ROUND states.
REQ-011 SHALL have port done, output, 1 bit: result valid; held high until the next accepted start.
REQ-012 SHALL have port result, output, 1+EXP_W+MAN_W bits: {sign, biased exponent, mantissa}.
REQ-013 SHALL have port ovf, output, 1 bit: result saturated to infinity; valid while done is high.

Function
REQ-014 SHALL implement states IDLE, NORM, ROUND and DONE; start SHALL be accepted only in IDLE or DONE and SHALL be ignored while busy.
REQ-015 On an accepted start, the block SHALL capture sgn=din[IN_W-1] and mag=din[IN_W-2:0], clear done, load exp=BIAS+(IN_W-2-FRAC_W) with BIAS=2^(EXP_W-1)-1, and enter NORM.
REQ-016 In NORM, each cycle SHALL either shift mag left by 1 and decrement exp (when mag MSB=0 and mag!=0), or go to ROUND (when mag MSB=1 or mag==0); only one shift per cycle is allowed.
REQ-017 Latency SHALL be deterministic: done rises on clock edge E0+lz+2, where E0 is the start-capture edge and lz is the leading-zero count of mag (lz=0 for mag==0).
REQ-018 In ROUND, mantissa SHALL be mag[IN_W-3 -: MAN_W]; the remaining low bits form guard/sticky; with ROUND_EN=1 the block SHALL round up when above half, or at exactly half when the mantissa LSB=1.
REQ-019 A rounding carry-out SHALL zero the mantissa and increment exp by 1.
REQ-020 If exp reaches 2^EXP_W-1 or more, result SHALL be {sgn, all-ones, zero} and ovf=1.
REQ-021 If exp would reach 0 during NORM, result SHALL flush to {sgn, zero} with ovf=0; subnormals are not produced.
REQ-022 mag==0 SHALL yield {sgn, 0, 0}, preserving sign: 16'h8000 gives -0.
REQ-023 result and ovf SHALL be registered, updated only on the ROUND->DONE transition, and held stable in DONE.
REQ-024 A start in DONE SHALL begin a new conversion on that edge, with done dropping on the same edge (back-to-back operation).

Reset
REQ-025 reset low SHALL immediately force state=IDLE, done=0, busy=0, ovf=0, result=0, discarding any operation in flight.
REQ-026 After reset release, the first start SHALL be accepted on the first rising clk edge at which it is sampled high.

Structure
REQ-027 Package fix_float_pkg SHALL hold the state enum, the parameter defaults and a BIAS/start-exponent function.
REQ-028 Round logic SHALL reside in one combinational sub-module fp_round_rne (inputs mantissa, guard bits, exp; outputs rounded mantissa, exp, ovf).
REQ-029 Design SHALL be synthesizable, with no delays and no memory access inside the block.

Verification (defaults unless stated)
REQ-030 din=16'h0100 (+1.0): result 16'h3C00 with done at E0+8.
REQ-031 din=16'h8180 (-1.5): result 16'hBE00.
REQ-032 din=16'h7FFF: ROUND_EN=1 gives 16'h5800; ROUND_EN=0 gives 16'h57FF; done at E0+2 in both cases.
REQ-033 Tie cases: din=16'h4008 gives 16'h5400 (even, held); din=16'h4018 gives 16'h5402 (odd, rounded up).
REQ-034 din=16'h0000 gives 16'h0000 and din=16'h8000 gives 16'h8000, both with done at E0+2.
REQ-035 Control cases: start pulsed while busy is ignored and the first result is unchanged; reset asserted mid-NORM clears done, busy and result asynchronously; a back-to-back start from DONE completes correctly.
